// File: rtl/sd_pkg.sv
// Shared constants and state encodings for the SD sector reader and its
// SPI engine handshake.
package sd_pkg;

    localparam logic [1:0] SPI_CMD_INIT = 2'd0;
    localparam logic [1:0] SPI_CMD_XFER = 2'd1;
    localparam logic [1:0] SPI_CMD_CSLO = 2'd2;
    localparam logic [1:0] SPI_CMD_CSHI = 2'd3;

    localparam logic [7:0] CMD17_OP    = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] TOKEN_IDLE  = 8'hFF;

    typedef enum logic [2:0] {
        ERR_OK            = 3'd0,
        ERR_R1_TIMEOUT    = 3'd1,
        ERR_R1_NONZERO    = 3'd2,
        ERR_TOKEN_TIMEOUT = 3'd3,
        ERR_DATA_TOKEN    = 3'd4
    } err_code_t;

    typedef enum logic [3:0] {
        IDLE, CS_LO, CMD, R1, TOK, DATA, CRC, CS_HI, FIN
    } rd_state_t;

    typedef enum logic [1:0] {
        T_IDLE, T_ISSUE, T_WAIT, T_GAP
    } xfer_state_t;

endpackage

// File: rtl/sd_spi_xfer.sv
// One engine operation: raise spi_sent until the engine goes busy, wait for
// it to finish, then keep spi_sent low long enough for its edge latch.
module sd_spi_xfer
    import sd_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx,
    output logic       xfer_done,
    output logic [7:0] rx,
    output logic       spi_sent,
    output logic [1:0] spi_cmd,
    output logic [7:0] spi_out,
    input  logic [7:0] spi_din,
    input  logic       eng_busy
);

    xfer_state_t state, state_n;
    logic        pend;
    logic [7:0]  gap_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= T_IDLE;
            pend    <= 1'b0;
            spi_cmd <= SPI_CMD_INIT;
            spi_out <= TOKEN_IDLE;
            rx      <= TOKEN_IDLE;
            gap_cnt <= 8'd0;
        end else begin
            state <= state_n;
            // cmd/tx are captured here so they stay stable for the whole op
            if (start) begin
                pend    <= 1'b1;
                spi_cmd <= cmd;
                spi_out <= tx;
            end else if (state == T_IDLE && state_n == T_ISSUE) begin
                pend <= 1'b0;
            end
            if (state == T_WAIT && !eng_busy)
                rx <= spi_din;
            gap_cnt <= (state == T_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_n   = state;
        spi_sent  = 1'b0;
        xfer_done = 1'b0;
        case (state)
            T_IDLE:  if (pend && !eng_busy) state_n = T_ISSUE;
            T_ISSUE: begin
                spi_sent = 1'b1;
                if (eng_busy) state_n = T_WAIT;
            end
            T_WAIT:  if (!eng_busy) state_n = T_GAP;
            T_GAP: begin
                if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                    xfer_done = 1'b1;
                    state_n   = T_IDLE;
                end
            end
            default: state_n = T_IDLE;
        endcase
    end

endmodule

// File: rtl/sd_sector_reader.sv
// CMD17 single-sector read sequencer driving the byte-level SPI SD engine;
// received data bytes are streamed out on a buffer write port.
module sd_sector_reader
    import sd_pkg::*;
#(
    parameter int R1_POLL_MAX    = 8,
    parameter int TOKEN_POLL_MAX = 4096,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] lba,
    input  logic        sdhc,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [7:0]  r1,
    output logic        data_we,
    output logic [8:0]  data_addr,
    output logic [7:0]  data_out,
    output logic        spi_sent,
    output logic [1:0]  spi_cmd,
    output logic [7:0]  spi_out,
    input  logic [7:0]  spi_din,
    input  logic [1:0]  spi_st
);

    rd_state_t   state, state_n;
    err_code_t   err_q, err_n;
    logic [12:0] cnt, cnt_n;
    logic [31:0] arg;
    logic        inflight, start, op_active, xfer_done;
    logic [1:0]  op_cmd;
    logic [7:0]  op_tx, rx;
    logic        accept, finish, r1_cap, data_wr, addr_clr;
    logic        spi_st_unused;

    assign spi_st_unused = spi_st[1];
    assign err_code      = err_q;
    // a new op is launched the cycle after the previous one reports done
    assign start         = op_active && !inflight;

    sd_spi_xfer #(.GAP_CYCLES(GAP_CYCLES)) u_xfer (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cmd       (op_cmd),
        .tx        (op_tx),
        .xfer_done (xfer_done),
        .rx        (rx),
        .spi_sent  (spi_sent),
        .spi_cmd   (spi_cmd),
        .spi_out   (spi_out),
        .spi_din   (spi_din),
        .eng_busy  (spi_st[0])
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            err_q     <= ERR_OK;
            cnt       <= 13'd0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            r1        <= 8'hFF;
            data_we   <= 1'b0;
            data_addr <= 9'd0;
            data_out  <= 8'd0;
        end else begin
            state   <= state_n;
            err_q   <= err_n;
            cnt     <= cnt_n;
            done    <= finish;
            data_we <= data_wr;
            if (start)          inflight <= 1'b1;
            else if (xfer_done) inflight <= 1'b0;
            if (accept) begin
                busy  <= 1'b1;
                error <= 1'b0;
            end
            if (finish) begin
                busy  <= 1'b0;
                error <= (err_n != ERR_OK);
            end
            if (r1_cap) r1 <= rx;
            if (addr_clr) data_addr <= 9'd0;
            if (data_wr) begin
                data_out  <= rx;
                data_addr <= cnt[8:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) arg <= sdhc ? lba : {lba[22:0], 9'd0};
    end

    always_comb begin
        state_n   = state;
        err_n     = err_q;
        cnt_n     = cnt;
        op_active = 1'b1;
        op_cmd    = SPI_CMD_XFER;
        op_tx     = TOKEN_IDLE;
        accept    = 1'b0;
        finish    = 1'b0;
        r1_cap    = 1'b0;
        data_wr   = 1'b0;
        addr_clr  = 1'b0;
        case (state)
            IDLE: begin
                op_active = 1'b0;
                if (rd_req) begin
                    accept  = 1'b1;
                    err_n   = ERR_OK;
                    state_n = CS_LO;
                end
            end
            CS_LO: begin
                op_cmd = SPI_CMD_CSLO;
                if (xfer_done) begin
                    state_n = CMD;
                    cnt_n   = 13'd0;
                end
            end
            CMD: begin
                case (cnt[2:0])
                    3'd0:    op_tx = CMD17_OP;
                    3'd1:    op_tx = arg[31:24];
                    3'd2:    op_tx = arg[23:16];
                    3'd3:    op_tx = arg[15:8];
                    3'd4:    op_tx = arg[7:0];
                    default: op_tx = TOKEN_IDLE;
                endcase
                if (xfer_done) begin
                    cnt_n = cnt + 13'd1;
                    if (cnt == 13'd5) begin
                        state_n = R1;
                        cnt_n   = 13'd0;
                    end
                end
            end
            R1: begin
                if (xfer_done) begin
                    r1_cap = 1'b1;
                    cnt_n  = cnt + 13'd1;
                    if (!rx[7]) begin
                        state_n = (rx == 8'h00) ? TOK : CS_HI;
                        cnt_n   = 13'd0;
                        if (rx != 8'h00) err_n = ERR_R1_NONZERO;
                    end else if (cnt == 13'(R1_POLL_MAX - 1)) begin
                        err_n   = ERR_R1_TIMEOUT;
                        state_n = CS_HI;
                        cnt_n   = 13'd0;
                    end
                end
            end
            TOK: begin
                if (xfer_done) begin
                    cnt_n = cnt + 13'd1;
                    if (rx == TOKEN_START) begin
                        state_n  = DATA;
                        cnt_n    = 13'd0;
                        addr_clr = 1'b1;
                    end else if (rx[7:5] == 3'b000) begin
                        err_n   = ERR_DATA_TOKEN;
                        state_n = CS_HI;
                        cnt_n   = 13'd0;
                    end else if (cnt == 13'(TOKEN_POLL_MAX - 1)) begin
                        err_n   = ERR_TOKEN_TIMEOUT;
                        state_n = CS_HI;
                        cnt_n   = 13'd0;
                    end
                end
            end
            DATA: begin
                if (xfer_done) begin
                    data_wr = 1'b1;
                    cnt_n   = cnt + 13'd1;
                    if (cnt == 13'd511) begin
                        state_n = CRC;
                        cnt_n   = 13'd0;
                    end
                end
            end
            CRC: begin
                if (xfer_done) begin
                    cnt_n = cnt + 13'd1;
                    if (cnt == 13'd1) begin
                        state_n = CS_HI;
                        cnt_n   = 13'd0;
                    end
                end
            end
            CS_HI: begin
                // first op releases CS, second clocks 8 bits with CS high
                if (cnt == 13'd0) op_cmd = SPI_CMD_CSHI;
                if (xfer_done) begin
                    if (cnt == 13'd0) begin
                        cnt_n = 13'd1;
                    end else begin
                        state_n = FIN;
                        finish  = 1'b1;
                    end
                end
            end
            FIN: begin
                op_active = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                op_active = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: behavioural SPI engine with an SD card model,
// a table of read scenarios and a few hand-written reset/busy sequences.
module tb_sd_sector_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] lba = 32'd0;
    logic        sdhc = 1'b0;
    logic        busy, done, error;
    logic [2:0]  err_code;
    logic [7:0]  r1;
    logic        data_we;
    logic [8:0]  data_addr;
    logic [7:0]  data_out;
    logic        spi_sent;
    logic [1:0]  spi_cmd;
    logic [7:0]  spi_out;
    logic [7:0]  spi_din;
    logic [1:0]  spi_st;

    sd_sector_reader dut (
        .clock(clock), .reset(reset), .rd_req(rd_req), .lba(lba), .sdhc(sdhc),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .r1(r1),
        .data_we(data_we), .data_addr(data_addr), .data_out(data_out),
        .spi_sent(spi_sent), .spi_cmd(spi_cmd), .spi_out(spi_out),
        .spi_din(spi_din), .spi_st(spi_st)
    );

    always #20 clock = ~clock;

    // card behaviour for the current scenario (0 = never answers)
    int         cfg_r1_at = 0;
    logic [7:0] cfg_r1_val = 8'h00;
    int         cfg_tok_at = 0;
    logic [7:0] cfg_tok_val = 8'hFE;

    logic       s1, s2, s3, eng_busy, cs_n;
    logic [1:0] ecnt;
    int         phase, pcnt;
    int         r1_polls = 0, tok_polls = 0, hi_tx = 0, init_cmds = 0;
    logic [7:0] mosi_q[$];

    assign spi_st = {1'b0, eng_busy};

    function automatic logic [7:0] card_byte(input int ph, input int pc);
        case (ph)
            1:       return (cfg_r1_at != 0 && pc == cfg_r1_at - 1) ? cfg_r1_val : 8'hFF;
            2:       return (cfg_tok_at != 0 && pc == cfg_tok_at - 1) ? cfg_tok_val : 8'hFF;
            3:       return pc[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    // engine: 2-stage latch on spi_sent, rising edge starts a 2-cycle busy op
    always @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            eng_busy <= 1'b0; ecnt <= 2'd0; cs_n <= 1'b1;
            phase <= 5; pcnt <= 0; spi_din <= 8'hFF;
        end else begin
            s1 <= spi_sent; s2 <= s1; s3 <= s2;
            if (eng_busy) begin
                if (ecnt == 2'd0) eng_busy <= 1'b0;
                else ecnt <= ecnt - 2'd1;
            end else if (s2 && !s3) begin
                eng_busy <= 1'b1;
                ecnt <= 2'd1;
                case (spi_cmd)
                    2'd0: init_cmds <= init_cmds + 1;
                    2'd2: begin
                        cs_n <= 1'b0; phase <= 0; pcnt <= 0;
                        r1_polls <= 0; tok_polls <= 0; hi_tx <= 0;
                        mosi_q.delete();
                    end
                    2'd3: cs_n <= 1'b1;
                    default: begin
                        if (cs_n) begin
                            hi_tx <= hi_tx + 1;
                            spi_din <= 8'hFF;
                        end else begin
                            spi_din <= card_byte(phase, pcnt);
                            case (phase)
                                0: begin
                                    mosi_q.push_back(spi_out);
                                    if (pcnt == 5) begin phase <= 1; pcnt <= 0; end
                                    else pcnt <= pcnt + 1;
                                end
                                1: begin
                                    r1_polls <= r1_polls + 1;
                                    if (cfg_r1_at != 0 && pcnt == cfg_r1_at - 1) begin
                                        phase <= (cfg_r1_val == 8'h00) ? 2 : 5; pcnt <= 0;
                                    end else pcnt <= pcnt + 1;
                                end
                                2: begin
                                    tok_polls <= tok_polls + 1;
                                    if (cfg_tok_at != 0 && pcnt == cfg_tok_at - 1) begin
                                        phase <= (cfg_tok_val == 8'hFE) ? 3 : 5; pcnt <= 0;
                                    end else pcnt <= pcnt + 1;
                                end
                                3: begin
                                    if (pcnt == 511) begin phase <= 4; pcnt <= 0; end
                                    else pcnt <= pcnt + 1;
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // scoreboard and handshake monitors
    logic [16:0] exp_q[$];
    int dcount = 0, dmis = 0, done_cnt = 0, hs_bad = 0, low_run = 100;
    logic sent_prev = 1'b0;

    always @(negedge clock) begin
        if (done) done_cnt <= done_cnt + 1;
        if (data_we) begin
            dcount <= dcount + 1;
            if (exp_q.size() == 0) dmis <= dmis + 1;
            else if (exp_q.pop_front() !== {data_addr, data_out}) dmis <= dmis + 1;
        end
        if (spi_sent && !sent_prev) begin
            if (low_run < 2 || spi_st[0]) hs_bad <= hs_bad + 1;
        end
        low_run   <= spi_sent ? 0 : (low_run < 100 ? low_run + 1 : low_run);
        sent_prev <= spi_sent;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_txn(input logic s, input logic [31:0] l);
        @(negedge clock);
        sdhc = s; lba = l; rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 70000; c++) begin
            if (done) begin seen = 1; break; end
            @(negedge clock);
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    function automatic logic [47:0] mosi_word();
        logic [47:0] w;
        w = '0;
        for (int i = 0; i < mosi_q.size() && i < 6; i++) w = {w[39:0], mosi_q[i]};
        return w;
    endfunction

    typedef struct {
        logic        sdhc;
        logic [31:0] lba;
        int          r1_at;
        logic [7:0]  r1_val;
        int          tok_at;
        logic [7:0]  tok_val;
        logic [47:0] exp_cmd;
        logic [2:0]  exp_err;
        logic [7:0]  exp_r1;
        int          exp_ndata;
        int          exp_r1_polls;
        int          exp_tok_polls;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, n0, m0;
        string nm;

        vecs[0] = '{1'b1, 32'h0000_1234, 2, 8'h00, 3, 8'hFE, 48'h5100001234FF, 3'd0, 8'h00, 512, 2, 3};
        vecs[1] = '{1'b0, 32'h0000_0003, 1, 8'h00, 1, 8'hFE, 48'h5100000600FF, 3'd0, 8'h00, 512, 1, 1};
        vecs[2] = '{1'b0, 32'h89AB_CDEF, 0, 8'h00, 0, 8'hFE, 48'h51579BDE00FF, 3'd1, 8'hFF, 0, 8, 0};
        vecs[3] = '{1'b1, 32'hDEAD_BEEF, 1, 8'h05, 0, 8'hFE, 48'h51DEADBEEFFF, 3'd2, 8'h05, 0, 1, 0};
        vecs[4] = '{1'b1, 32'h0000_0007, 1, 8'h00, 2, 8'h08, 48'h5100000007FF, 3'd4, 8'h00, 0, 1, 2};
        vecs[5] = '{1'b1, 32'h0000_0008, 1, 8'h00, 0, 8'hFE, 48'h5100000008FF, 3'd3, 8'h00, 0, 1, 4096};

        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_r1", r1, 8'hFF);
        chk("rst_spi_sent", spi_sent, 0);
        chk("rst_spi_cmd", spi_cmd, 0);
        chk("rst_spi_out", spi_out, 8'hFF);
        chk("rst_data", {data_we, data_addr, data_out}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 6; v++) begin
            nm = $sformatf("v%0d", v);
            cfg_r1_at = vecs[v].r1_at;  cfg_r1_val = vecs[v].r1_val;
            cfg_tok_at = vecs[v].tok_at; cfg_tok_val = vecs[v].tok_val;
            exp_q.delete();
            for (int i = 0; i < vecs[v].exp_ndata; i++) exp_q.push_back({9'(i), 8'(i)});
            d0 = dcount; n0 = done_cnt; m0 = dmis;
            start_txn(vecs[v].sdhc, vecs[v].lba);
            chk({nm, "_busy"}, busy, 1);
            wait_done(nm);
            chk({nm, "_err_code"}, err_code, vecs[v].exp_err);
            chk({nm, "_error"}, error, (vecs[v].exp_err != 3'd0));
            chk({nm, "_r1"}, r1, vecs[v].exp_r1);
            chk({nm, "_busy_at_done"}, busy, 0);
            repeat (3) @(negedge clock);
            chk({nm, "_done_pulses"}, done_cnt - n0, 1);
            chk({nm, "_ndata"}, dcount - d0, vecs[v].exp_ndata);
            chk({nm, "_data_mismatch"}, dmis - m0, 0);
            chk({nm, "_cmd_len"}, mosi_q.size(), 6);
            chk({nm, "_cmd_bytes"}, mosi_word(), vecs[v].exp_cmd);
            chk({nm, "_r1_polls"}, r1_polls, vecs[v].exp_r1_polls);
            chk({nm, "_tok_polls"}, tok_polls, vecs[v].exp_tok_polls);
            chk({nm, "_cs_high"}, cs_n, 1);
            chk({nm, "_cs_high_tx"}, hi_tx, 1);
        end

        // rd_req while busy must be ignored
        cfg_r1_at = 0;
        n0 = done_cnt;
        start_txn(1'b1, 32'h0000_0011);
        repeat (20) @(negedge clock);
        chk("ign_busy_before", busy, 1);
        sdhc = 1'b1; lba = 32'h0000_0022; rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        wait_done("ign");
        repeat (30) @(negedge clock);
        chk("ign_done_pulses", done_cnt - n0, 1);
        chk("ign_busy_after", busy, 0);
        chk("ign_spi_sent", spi_sent, 0);
        chk("ign_cmd_bytes", mosi_word(), 48'h5100000011FF);

        // reset in the middle of the data phase
        cfg_r1_at = 1; cfg_r1_val = 8'h00; cfg_tok_at = 1; cfg_tok_val = 8'hFE;
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), 8'(i)});
        d0 = dcount; n0 = done_cnt;
        start_txn(1'b1, 32'h0000_0042);
        for (int c = 0; c < 20000; c++) begin
            if (dcount - d0 >= 100) break;
            @(negedge clock);
        end
        chk("mid_reached_data", (dcount - d0 >= 100), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_busy", busy, 0);
        chk("mid_spi_sent", spi_sent, 0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("mid_no_done", done_cnt - n0, 0);
        chk("mid_idle_busy", busy, 0);
        exp_q.delete();

        // recovers normally after the reset
        cfg_r1_at = 1; cfg_r1_val = 8'h05;
        start_txn(1'b1, 32'h0000_0001);
        wait_done("post");
        chk("post_err_code", err_code, 3'd2);

        repeat (5) @(negedge clock);
        chk("handshake_gap", hs_bad, 0);
        chk("no_init_cmd", init_cmds, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_sector_reader.md
Name: sd_sector_reader

Overview:
- Sequences the byte-level SPI SD-card engine to read one 512-byte sector (CMD17) from a host request.
- Performs CS low, sends the 6-byte command, polls R1, waits for the start token, streams 512 data bytes to a buffer write port, discards the CRC, then raises CS.
- Sits between the CPU/MMIO side and the SPI engine. It is the engine's only client while it is busy.
- Card init (the engine's 80-clock command) remains the CPU's job; this block never issues engine command 00.

Parameters:
- R1_POLL_MAX, 8, maximum 0xFF bytes sent while waiting for R1 (bit7=0).
- TOKEN_POLL_MAX, 4096, maximum bytes sent while waiting for the 0xFE start token.
- GAP_CYCLES, 2, spi_sent low cycles required between engine requests; must be at least 2 to satisfy the engine's 2-stage edge latch.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  single-cycle pulse; starts a read. Ignored while busy=1.
- lba  in  32  sector number, sampled on an accepted rd_req.
- sdhc  in  1  1 = block addressing (arg = lba); 0 = byte addressing (arg = lba<<9, upper bits dropped). Sampled with lba.
- busy  out  1  high from the cycle after an accepted rd_req until the cycle done pulses.
- done  out  1  one-cycle pulse at end of transaction, on both success and error.
- error  out  1  valid with done; held until the next accepted rd_req.
- err_code  out  3  0 ok, 1 R1 timeout, 2 R1 nonzero, 3 token timeout, 4 data error token.
- r1  out  8  last R1 byte received.
- data_we  out  1  buffer write strobe, one cycle per data byte.
- data_addr  out  9  byte index 0..511.
- data_out  out  8  received byte.
- spi_sent  out  1  request to the engine (level; engine edge-detects it).
- spi_cmd  out  2  engine command: 01 transmit, 02 CS=0, 03 CS=1.
- spi_out  out  8  byte to transmit.
- spi_din  in  8  byte received by the engine.
- spi_st  in  2  engine status: [0] busy, [1] timeout (unused here).

Behaviour:
- Reset values: spi_sent=0, spi_cmd=0, spi_out=0xFF, busy=0, done=0, error=0, err_code=0, r1=0xFF, data_we=0, data_addr=0, data_out=0; top FSM=IDLE, transfer FSM=T_IDLE.
- Engine transfer sub-FSM (one engine op):
  - T_ISSUE: spi_sent=1, spi_cmd and spi_out held stable; stay until spi_st[0]=1.
  - T_WAIT: spi_sent=0; stay until spi_st[0]=0, then spi_din is valid.
  - T_GAP: hold spi_sent=0 for GAP_CYCLES cycles, then signal xfer_done (1 cycle) with the captured rx byte.
  - The transfer FSM never drives spi_sent high while spi_st[0]=1 from a previous op.
- Top FSM:
  - IDLE: on rd_req, latch arg, clear error/err_code, set busy, go to CS_LO.
  - CS_LO: engine cmd 02, then go to CMD.
  - CMD: 6 transmits, bytes 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0xFF. Go to R1.
  - R1: transmit 0xFF and capture r1.
    - rx[7]=0 and rx=0x00: go to TOK.
    - rx[7]=0 and rx≠0x00: err 2, go to CS_HI.
    - R1_POLL_MAX bytes with rx[7]=1: err 1, go to CS_HI.
  - TOK: transmit 0xFF.
    - rx=0xFE: go to DATA with data_addr=0.
    - rx[7:5]=000: err 4, go to CS_HI.
    - Otherwise continue polling; after TOKEN_POLL_MAX bytes: err 3, go to CS_HI.
  - DATA: 512 transmits of 0xFF. On each xfer_done: data_we=1, data_out=rx, data_addr=index. Index increments after the write. After index 511, go to CRC.
  - CRC: 2 transmits of 0xFF, bytes discarded.
  - CS_HI: engine cmd 03, then one extra transmit of 0xFF (8 clocks with CS high), then FIN.
  - FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Poll counters are 13 bits and are cleared on entry to R1 and TOK.
- data_addr is 9 bits and never wraps within a transaction.
- rd_req arriving in the same cycle as done is ignored; the host must re-request.
- Reset mid-transaction:
  - Immediate return to IDLE, spi_sent=0, no done pulse.
  - CS recovery relies on the engine being reset from the same top-level reset net.
- Total latency (nominal, card responds at the first R1 poll and the first token poll): (1+6+1+1+512+2+1+1) engine ops × (engine op ≈ 40 cycles + handshake ≈ 5) + 1.

Decomposition:
- Package sd_pkg:
  - engine command constants SPI_CMD_INIT=0, SPI_CMD_XFER=1, SPI_CMD_CSLO=2, SPI_CMD_CSHI=3;
  - CMD17 opcode 0x51; tokens 0xFE/0xFF;
  - err_code enumeration;
  - top FSM state enum.
- Sub-module sd_spi_xfer: the T_ISSUE/T_WAIT/T_GAP handshake.
  - Inputs: start, cmd, tx.
  - Outputs: xfer_done, rx.

Test Plan:
- Behavioural engine model plus card model, sdhc=1, lba=0x00001234. Card returns R1=0x00 on the 2nd poll, token on the 3rd poll, data[i]=i[7:0] → MOSI stream is 51 00 00 12 34 FF; 512 data_we pulses with data_addr 0..511 and data_out=i&0xFF; done with error=0; CS high at end.
- sdhc=0, lba=0x00000003 → argument bytes 00 00 06 00.
- Card never answers (always 0xFF) → exactly 8 R1 polls, err_code=1, CS returned high, done pulses once.
- R1=0x05 → err_code=2, r1=0x05, no data_we.
- Token phase returns 0x08 → err_code=4; token phase always 0xFF → err_code=3 after 4096 polls.
- Handshake and reset checks:
  - spi_sent is never high for 2 consecutive ops without ≥2 low cycles between them.
  - rd_req while busy is ignored.
  - reset asserted mid-DATA → busy=0 and spi_sent=0 the next cycle, no done pulse.
